// File: rtl/score_board_if.sv
// Goal/clear inputs and score/display outputs of the score board.
// The game stage drives the master side; the score board is the slave.
interface score_board_if;
    logic       clear;
    logic       goal_p1;
    logic       goal_p2;
    logic [3:0] p1_ones;
    logic [2:0] p1_tens;
    logic [3:0] p2_ones;
    logic [2:0] p2_tens;
    logic       game_over;
    logic [1:0] winner;
    logic [6:0] seg;
    logic [3:0] an;

    modport master (
        output clear, goal_p1, goal_p2,
        input  p1_ones, p1_tens, p2_ones, p2_tens, game_over, winner, seg, an
    );

    modport slave (
        input  clear, goal_p1, goal_p2,
        output p1_ones, p1_tens, p2_ones, p2_tens, game_over, winner, seg, an
    );
endinterface

// File: rtl/score_board.sv
// Two-player BCD score keeper with win detection and a blinking
// four-digit multiplexed seven-segment display.
module score_board #(
    parameter int unsigned WIN_SCORE   = 7,
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned LOCKOUT     = 1024,
    parameter int unsigned BLINK_DIV   = 8
) (
    input logic          clk,
    input logic          rst,
    score_board_if.slave bus
);
    localparam int unsigned LockW  = (LOCKOUT > 1) ? $clog2(LOCKOUT) : 1;
    localparam int unsigned RefW   = $clog2(REFRESH_DIV);
    localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [LockW-1:0]  LockLoad = LockW'(LOCKOUT - 1);
    localparam logic [RefW-1:0]   RefMax   = RefW'(REFRESH_DIV - 1);
    localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(BLINK_DIV - 1);
    localparam logic [6:0]        WinBcd   = {3'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};

    typedef enum logic [0:0] {StPlay, StGameOver} state_e;

    state_e           state_q, state_d;
    logic [1:0]       winner_q, winner_d;
    logic [1:0]       goal_q, goal_prev_q;
    logic [1:0]       rise, cnt, hit;
    // Scores held as {tens[2:0], ones[3:0]}; index 0 is player 1.
    logic [6:0]       score_q [2];
    logic [6:0]       score_d [2];
    logic [LockW-1:0] lock_q [2];
    logic [LockW-1:0] lock_d [2];

    logic [RefW-1:0]   ref_q, ref_d;
    logic [1:0]        sel_q, sel_d;
    logic [BlinkW-1:0] blink_q, blink_d;
    logic              phase_q, phase_d;
    logic [3:0]        an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              ref_wrap, blank;
    logic [3:0]        digit;

    function automatic logic [6:0] bcd_inc(logic [6:0] s);
        if (s[3:0] == 4'd9) begin
            if (s[6:4] == 3'd7) return s;
            return {s[6:4] + 3'd1, 4'd0};
        end
        return {s[6:4], s[3:0] + 4'd1};
    endfunction

    function automatic logic [6:0] seg_pat(logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b1000000;
            4'd1:    p = 7'b1111001;
            4'd2:    p = 7'b0100100;
            4'd3:    p = 7'b0110000;
            4'd4:    p = 7'b0011001;
            4'd5:    p = 7'b0010010;
            4'd6:    p = 7'b0000010;
            4'd7:    p = 7'b1111000;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0010000;
            default: p = 7'b1111111;
        endcase
        return p;
    endfunction

    always_comb begin
        rise     = goal_q & ~goal_prev_q;
        cnt      = '0;
        hit      = '0;
        state_d  = state_q;
        winner_d = winner_q;
        for (int p = 0; p < 2; p++) begin
            cnt[p]     = rise[p] && (lock_q[p] == '0) && (state_q == StPlay) && !bus.clear;
            score_d[p] = cnt[p] ? bcd_inc(score_q[p]) : score_q[p];
            hit[p]     = cnt[p] && (score_d[p] == WinBcd);
            if (cnt[p])                lock_d[p] = LockLoad;
            else if (lock_q[p] != '0)  lock_d[p] = lock_q[p] - LockW'(1);
            else                       lock_d[p] = lock_q[p];
        end
        if (bus.clear) begin
            state_d  = StPlay;
            winner_d = 2'b00;
            for (int p = 0; p < 2; p++) begin
                score_d[p] = '0;
                lock_d[p]  = '0;
            end
        end else if (|hit) begin
            state_d  = StGameOver;
            winner_d = hit;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StPlay;
            winner_q    <= 2'b00;
            goal_q      <= 2'b00;
            goal_prev_q <= 2'b00;
            for (int p = 0; p < 2; p++) begin
                score_q[p] <= '0;
                lock_q[p]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            winner_q    <= winner_d;
            goal_q      <= {bus.goal_p2, bus.goal_p1};
            goal_prev_q <= goal_q;
            for (int p = 0; p < 2; p++) begin
                score_q[p] <= score_d[p];
                lock_q[p]  <= lock_d[p];
            end
        end
    end

    always_comb begin
        ref_wrap = (ref_q == RefMax);
        ref_d    = ref_wrap ? '0 : ref_q + RefW'(1);
        sel_d    = ref_wrap ? sel_q - 2'd1 : sel_q;
        blink_d  = blink_q;
        phase_d  = phase_q;
        if (state_q != StGameOver) begin
            blink_d = '0;
            phase_d = 1'b0;
        end else if (ref_wrap && (sel_q == 2'd0)) begin
            if (blink_q == BlinkMax) begin
                blink_d = '0;
                phase_d = ~phase_q;
            end else begin
                blink_d = blink_q + BlinkW'(1);
            end
        end
        unique case (sel_d)
            2'd3:    digit = {1'b0, score_q[0][6:4]};
            2'd2:    digit = score_q[0][3:0];
            2'd1:    digit = {1'b0, score_q[1][6:4]};
            default: digit = score_q[1][3:0];
        endcase
        // Blank the loser's pair of digits; a tie (11) blanks nothing.
        blank = (state_q == StGameOver) && phase_q &&
                (((winner_q == 2'b01) && !sel_d[1]) || ((winner_q == 2'b10) && sel_d[1]));
        seg_d = blank ? 7'b1111111 : seg_pat(digit);
        an_d  = ~(4'b0001 << sel_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_q   <= '0;
            sel_q   <= 2'd3;
            blink_q <= '0;
            phase_q <= 1'b0;
            an_q    <= 4'b0111;
            seg_q   <= 7'b1000000;
        end else begin
            ref_q   <= ref_d;
            sel_q   <= sel_d;
            blink_q <= blink_d;
            phase_q <= phase_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign bus.p1_ones   = score_q[0][3:0];
    assign bus.p1_tens   = score_q[0][6:4];
    assign bus.p2_ones   = score_q[1][3:0];
    assign bus.p2_tens   = score_q[1][6:4];
    assign bus.game_over = (state_q == StGameOver);
    assign bus.winner    = winner_q;
    assign bus.seg       = seg_q;
    assign bus.an        = an_q;
endmodule

// File: tb/tb_score_board.sv
// Self-checking bench for score_board: three instances with different
// parameter sets, a goal vector table with a scoreboard queue, and hand sequences.
module tb_score_board;
    typedef struct {
        bit g1;
        bit g2;
        bit clr;
        int s1;
        int s2;
        int go;
        int win;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] g1, g2, clr;
    int         checks   = 0;
    int         failures = 0;
    logic [6:0] seg_tab [10];
    vec_t       vecs [$];
    vec_t       exp_q [$];
    bit         blank [2][4];

    always #5 clk = ~clk;

    score_board_if if_a ();
    score_board_if if_b ();
    score_board_if if_c ();

    assign if_a.goal_p1 = g1[0];
    assign if_a.goal_p2 = g2[0];
    assign if_a.clear   = clr[0];
    assign if_b.goal_p1 = g1[1];
    assign if_b.goal_p2 = g2[1];
    assign if_b.clear   = clr[1];
    assign if_c.goal_p1 = g1[2];
    assign if_c.goal_p2 = g2[2];
    assign if_c.clear   = clr[2];

    score_board #(.WIN_SCORE(7), .REFRESH_DIV(3), .LOCKOUT(4), .BLINK_DIV(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a)
    );
    score_board #(.WIN_SCORE(12), .REFRESH_DIV(3), .LOCKOUT(4), .BLINK_DIV(1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b)
    );
    score_board #(.WIN_SCORE(79), .REFRESH_DIV(3), .LOCKOUT(4), .BLINK_DIV(8)) dut_c (
        .clk (clk),
        .rst (rst),
        .bus (if_c)
    );

    // w: 0 p1_ones, 1 p1_tens, 2 p2_ones, 3 p2_tens, 4 game_over, 5 winner, 6 seg, 7 an
    function automatic int pick(int w, logic [3:0] p1o, logic [2:0] p1t, logic [3:0] p2o,
                                logic [2:0] p2t, logic go, logic [1:0] win, logic [6:0] seg,
                                logic [3:0] an);
        case (w)
            0:       return int'(p1o);
            1:       return int'(p1t);
            2:       return int'(p2o);
            3:       return int'(p2t);
            4:       return int'(go);
            5:       return int'(win);
            6:       return int'(seg);
            default: return int'(an);
        endcase
    endfunction

    function automatic int get(int d, int w);
        case (d)
            0: return pick(w, if_a.p1_ones, if_a.p1_tens, if_a.p2_ones, if_a.p2_tens,
                           if_a.game_over, if_a.winner, if_a.seg, if_a.an);
            1: return pick(w, if_b.p1_ones, if_b.p1_tens, if_b.p2_ones, if_b.p2_tens,
                           if_b.game_over, if_b.winner, if_b.seg, if_b.an);
            default: return pick(w, if_c.p1_ones, if_c.p1_tens, if_c.p2_ones, if_c.p2_tens,
                                 if_c.game_over, if_c.winner, if_c.seg, if_c.an);
        endcase
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_state(string tag, int d, int s1, int s2, int go, int win);
        check({tag, " p1_ones"}, get(d, 0), s1 % 10);
        check({tag, " p1_tens"}, get(d, 1), s1 / 10);
        check({tag, " p2_ones"}, get(d, 2), s2 % 10);
        check({tag, " p2_tens"}, get(d, 3), s2 / 10);
        check({tag, " game_over"}, get(d, 4), go);
        check({tag, " winner"}, get(d, 5), win);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(int d, bit p1, bit p2);
        g1[d] = p1;
        g2[d] = p2;
        tick();
        g1[d] = 1'b0;
        g2[d] = 1'b0;
        repeat (8) tick();
    endtask

    task automatic do_clear(int d);
        clr[d] = 1'b1;
        tick();
        clr[d] = 1'b0;
    endtask

    // Align to the first cycle in which an switches to 0111.
    task automatic sync_round(string tag, int d);
        int  prev;
        bit  found;
        prev  = get(d, 7);
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            tick();
            if (get(d, 7) == 7 && prev != 7) found = 1'b1;
            else prev = get(d, 7);
        end
        check({tag, " sync to an=0111"}, int'(found), 1);
    endtask

    initial begin
        vec_t v;
        vec_t e;
        int   an_exp;
        int   dig_exp;
        seg_tab[0] = 7'b1000000;
        seg_tab[1] = 7'b1111001;
        seg_tab[2] = 7'b0100100;
        seg_tab[3] = 7'b0110000;
        seg_tab[4] = 7'b0011001;
        seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010;
        seg_tab[7] = 7'b1111000;
        seg_tab[8] = 7'b0000000;
        seg_tab[9] = 7'b0010000;

        // Vector table for the WIN_SCORE=12 instance.
        for (int i = 1; i <= 12; i++)
            vecs.push_back('{g1: 0, g2: 1, clr: 0, s1: 0, s2: i, go: int'(i == 12),
                             win: (i == 12) ? 2 : 0});
        vecs.push_back('{g1: 0, g2: 1, clr: 0, s1: 0, s2: 12, go: 1, win: 2});
        vecs.push_back('{g1: 1, g2: 0, clr: 0, s1: 0, s2: 12, go: 1, win: 2});
        vecs.push_back('{g1: 0, g2: 0, clr: 1, s1: 0, s2: 0, go: 0, win: 0});
        vecs.push_back('{g1: 0, g2: 1, clr: 1, s1: 0, s2: 0, go: 0, win: 0});
        vecs.push_back('{g1: 1, g2: 0, clr: 0, s1: 1, s2: 0, go: 0, win: 0});
        vecs.push_back('{g1: 1, g2: 1, clr: 0, s1: 2, s2: 1, go: 0, win: 0});

        g1  = '0;
        g2  = '0;
        clr = '0;
        rst = 1'b1;
        repeat (2) tick();
        for (int d = 0; d < 3; d++) begin
            check_state($sformatf("reset d%0d", d), d, 0, 0, 0, 0);
            check($sformatf("reset d%0d an", d), get(d, 7), 4'b0111);
            check($sformatf("reset d%0d seg", d), get(d, 6), 7'b1000000);
        end
        rst = 1'b0;
        tick();

        // Held goal counts once.
        g1[0] = 1'b1;
        repeat (20) tick();
        g1[0] = 1'b0;
        repeat (8) tick();
        check_state("held goal", 0, 1, 0, 0, 0);
        do_clear(0);
        check_state("clear after held", 0, 0, 0, 0, 0);

        // Second edge inside lockout is ignored; a later one counts.
        g1[0] = 1'b1;
        tick();
        g1[0] = 1'b0;
        repeat (2) tick();
        g1[0] = 1'b1;
        tick();
        g1[0] = 1'b0;
        repeat (8) tick();
        check_state("lockout", 0, 1, 0, 0, 0);
        pulse(0, 1'b1, 1'b0);
        check_state("after lockout", 0, 2, 0, 0, 0);

        // Both to 6, then a simultaneous winning goal: tie.
        do_clear(0);
        for (int i = 0; i < 3; i++) pulse(0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) pulse(0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) pulse(0, 1'b1, 1'b1);
        check_state("six all", 0, 6, 6, 0, 0);
        pulse(0, 1'b1, 1'b1);
        check_state("tie", 0, 7, 7, 1, 3);
        do_clear(0);
        check_state("clear after tie", 0, 0, 0, 0, 0);

        // Table-driven run with a scoreboard queue.
        foreach (vecs[i]) begin
            v = vecs[i];
            exp_q.push_back(v);
            clr[1] = v.clr;
            g1[1]  = v.g1;
            g2[1]  = v.g2;
            tick();
            g1[1] = 1'b0;
            g2[1] = 1'b0;
            tick();
            clr[1] = 1'b0;
            repeat (8) tick();
            e = exp_q.pop_front();
            check_state($sformatf("vec%0d", i), 1, e.s1, e.s2, e.go, e.win);
        end

        // Display scan with p1=25, p2=9.
        for (int i = 0; i < 9; i++) pulse(2, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) pulse(2, 1'b1, 1'b0);
        check_state("disp scores", 2, 25, 9, 0, 0);
        sync_round("disp", 2);
        for (int i = 0; i < 12; i++) begin
            an_exp = int'(~(4'b1000 >> (i / 3))) & 15;
            case (i / 3)
                0:       dig_exp = 2;
                1:       dig_exp = 5;
                2:       dig_exp = 0;
                default: dig_exp = 9;
            endcase
            check($sformatf("disp an c%0d", i), get(2, 7), an_exp);
            check($sformatf("disp seg c%0d", i), get(2, 6), int'(seg_tab[dig_exp]));
            tick();
        end

        // p1 wins 7-3, then blink on p2's digits in alternate rounds.
        for (int i = 0; i < 3; i++) pulse(0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) pulse(0, 1'b1, 1'b0);
        check_state("p1 win", 0, 7, 3, 1, 1);
        pulse(0, 1'b0, 1'b1);
        check_state("frozen", 0, 7, 3, 1, 1);
        sync_round("blink", 0);
        for (int r = 0; r < 2; r++) begin
            for (int s = 0; s < 4; s++) begin
                an_exp = int'(~(4'b1000 >> s)) & 15;
                check($sformatf("blink an r%0d s%0d", r, s), get(0, 7), an_exp);
                dig_exp = (s == 1) ? 7 : (s == 3) ? 3 : 0;
                blank[r][s] = (get(0, 6) == 7'h7f);
                if (s < 2 || !blank[r][s])
                    check($sformatf("blink seg r%0d s%0d", r, s), get(0, 6),
                          int'(seg_tab[dig_exp]));
                repeat (3) tick();
            end
            check($sformatf("blink pair r%0d", r), int'(blank[r][3]), int'(blank[r][2]));
        end
        check("blink alternates", int'(blank[1][2]), int'(!blank[0][2]));

        // Asynchronous reset mid-round.
        repeat (3) tick();
        #2;
        rst = 1'b1;
        #1;
        check("async rst an", get(0, 7), 4'b0111);
        check("async rst seg", get(0, 6), 7'b1000000);
        check_state("async rst", 0, 0, 0, 0, 0);
        rst = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/score_board.md
Name: score_board

Overview:
- Downstream consumer of the game stage's per-player goal indications.
- Keeps each player's score as BCD (tens 0–7, ones 0–9) and detects the winning score.
- Drives a four-digit multiplexed active-low seven-segment display.
- Feeds the BCD score back to the game stage's score inputs.

Parameters:
- WIN_SCORE, 7, score that ends the game; legal range 1..79.
- REFRESH_DIV, 50000, clk cycles each display digit is lit; must be ≥2.
- LOCKOUT, 1024, clk cycles a player's goal input is ignored after a counted goal.
- BLINK_DIV, 8, refresh rounds per half blink period in GAME_OVER.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- clear  input  1  synchronous score/game clear, level, one-cycle minimum
- goal_p1  input  1  level; high while the ball touches player 1's scoring wall
- goal_p2  input  1  level; high while the ball touches player 2's scoring wall
- p1_ones  output  4  player 1 score ones digit, BCD
- p1_tens  output  3  player 1 score tens digit
- p2_ones  output  4  player 2 score ones digit, BCD
- p2_tens  output  3  player 2 score tens digit
- game_over  output  1  high in GAME_OVER state
- winner  output  2  00 none, 01 p1, 10 p2, 11 tie
- seg  output  7  segments a..g on seg[0]..seg[6], active-low
- an  output  4  digit enables, active-low; an[3]=p1_tens, an[2]=p1_ones, an[1]=p2_tens, an[0]=p2_ones

Behaviour:
- Reset (rst high, asynchronous):
  - all score digits 0; game_over 0; winner 00; state PLAY.
  - lockout counters 0; edge registers 0; refresh counter 0; digit select 3.
  - an=4'b0111, seg=7'b1000000 (a '0' on p1_tens).
- Goal detect: each goal input is registered once. A counted goal needs all of:
  - a rising edge (current 1, previous 0);
  - that player's lockout counter at 0;
  - state PLAY;
  - clear low.
- Counted goal effects:
  - The score increments on the clock edge after the rising edge is seen: 1-cycle latency from registered edge to output.
  - ones 9 wraps to 0 and increments tens; tens saturates at 7 (79 is a hold).
  - That player's lockout counter loads LOCKOUT-1 and decrements to 0.
- Simultaneous goals in the same cycle: both players increment independently.
- Win check on the updated value, same cycle as the increment:
  - If either score equals WIN_SCORE: state to GAME_OVER, game_over=1.
  - winner: 01 if only p1 reached WIN_SCORE, 10 if only p2, 11 if both in the same cycle.
- GAME_OVER:
  - goals ignored and scores frozen.
  - Exits only on clear or rst.
- clear:
  - In any state, on the next edge: scores 0, lockouts 0, winner 00, game_over 0, state PLAY.
  - Any goal edge in the same cycle is discarded.
  - Display refresh counter is not affected.
- Display refresh:
  - The refresh counter counts 0..REFRESH_DIV-1; on wrap, digit select advances 3→2→1→0→3.
  - Exactly one an bit is low at a time, never zero or two; the transition is a single registered update.
  - seg shows the selected digit with standard patterns, registered in the same cycle as an:
    - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
    - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000 (seg[6]..seg[0])
  - Leading zero on tens is displayed, not blanked.
- Blink in GAME_OVER:
  - A blink counter counts completed 4-digit rounds; the blink phase toggles every BLINK_DIV rounds.
  - While the phase is 1, the non-winning player's digits show seg=1111111; an still cycles.
  - On a tie, nothing blanks.
  - The blink counter and phase reset to 0 on entry to PLAY.
- Outputs p*_ones/p*_tens are registered, not combinational.

Test Plan:
1. Use LOCKOUT=4, WIN_SCORE=7. Apply rst, then hold goal_p1 high 20 cycles -> p1_ones=1 exactly once; p2 unchanged; game_over=0.
2. Pulse goal_p1 twice with 2 cycles low between, both inside lockout -> p1_ones=1. Pulse again after 5 idle cycles -> p1_ones=2.
3. Use WIN_SCORE=12. Give p2 ten separated goals -> p2_tens=1, p2_ones=0. Two more -> p2 score 12, game_over=1, winner=10. A further goal_p2 edge -> score stays 12.
4. Set both scores to 6 (WIN_SCORE=7), then assert goal_p1 and goal_p2 in the same cycle -> both 7, winner=11, game_over=1. Then clear -> all digits 0, winner=00, game_over=0 one cycle later.
5. Use REFRESH_DIV=3, scores p1=25, p2=9 -> an sequence 0111,1011,1101,1110 with each an held 3 cycles; seg 0100100, 0010010, 1000000, 0010000.
6. Use BLINK_DIV=1 with p1 the winner -> in alternate rounds, digits on an[1]/an[0] show 1111111 while p1 digits stay lit. Assert rst mid-round -> an=0111, seg=1000000 immediately.
